// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default widths and width helper for the memory arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_LINE_W = 512;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  typedef logic [1:0] state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requestor-side and memory-controller-side signals of the arbiter
interface mem_arbiter_rr_if
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
);
  logic [N_PORTS-1:0] port_req;
  logic [N_PORTS-1:0] port_wr_en;
  logic [N_PORTS*ADDR_W-1:0] port_addr;
  logic [N_PORTS*LINE_W-1:0] port_wdata;
  logic [LINE_W-1:0] port_rdata;
  logic [N_PORTS-1:0] port_complete;
  logic port_err;
  logic mem_req;
  logic [ADDR_W-1:0] mem_address;
  logic mem_wr_en;
  logic [LINE_W-1:0] mem_data_out;
  logic [LINE_W-1:0] data_from_mem;
  logic mem_data_valid;
  modport slave (
    input port_req, port_wr_en, port_addr, port_wdata, data_from_mem, mem_data_valid,
    output port_rdata, port_complete, port_err, mem_req, mem_address, mem_wr_en, mem_data_out
  );
  modport master (
    output port_req, port_wr_en, port_addr, port_wdata, data_from_mem, mem_data_valid,
    input port_rdata, port_complete, port_err, mem_req, mem_address, mem_wr_en, mem_data_out
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from ptr with wrap
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // Walk from the far end back toward ptr so the nearest requester is written last.
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        valid = 1'b1;
      end
    end
    grant = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port round-robin arbiter in front of a single memory controller with timeout
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int TIMEOUT = 1023
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_rr_if.slave bus
);
  localparam int IW = clog2(N_PORTS);
  localparam int CW = TIMEOUT > 0 ? clog2(TIMEOUT + 1) : 1;
  state_t state;
  logic [IW-1:0] rr_ptr, grant_idx, pick_idx;
  logic [N_PORTS-1:0] grant_oh, pick_oh;
  logic pick_any;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q, rdata_q;
  logic wr_q, err_q, tmo;
  logic [CW-1:0] cnt;
  rr_pick #(.N(N_PORTS)) u_pick (
    .req(bus.port_req),
    .ptr(rr_ptr),
    .grant(pick_oh),
    .idx(pick_idx),
    .valid(pick_any)
  );
  // Fires on the edge that would bring the BUSY-cycle count up to TIMEOUT.
  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      grant_oh <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_any) begin
        state <= BUSY;
        grant_idx <= pick_idx;
        grant_oh <= pick_oh;
        addr_q <= bus.port_addr[pick_idx*ADDR_W +: ADDR_W];
        wr_q <= bus.port_wr_en[pick_idx];
        wdata_q <= bus.port_wdata[pick_idx*LINE_W +: LINE_W];
        cnt <= '0;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      if (bus.mem_data_valid) begin
        if (!wr_q) rdata_q <= bus.data_from_mem;
        state <= RESP;
      end else if (tmo) begin
        err_q <= 1'b1;
        state <= RESP;
      end
    end else begin
      rr_ptr <= (grant_idx == IW'(N_PORTS - 1)) ? '0 : grant_idx + IW'(1);
      err_q <= 1'b0;
      cnt <= '0;
      state <= IDLE;
    end
  end
  assign bus.mem_req = state == BUSY;
  assign bus.mem_address = addr_q;
  assign bus.mem_wr_en = wr_q;
  assign bus.mem_data_out = wdata_q;
  assign bus.port_rdata = rdata_q;
  assign bus.port_complete = state == RESP ? grant_oh : '0;
  assign bus.port_err = state == RESP && err_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: table-driven and scoreboard checks of the round-robin memory arbiter
module tb_mem_arbiter_rr;
  typedef struct {
    int port;
    bit wr;
    logic [63:0] addr;
    logic [7:0] wb;
    logic [7:0] rb;
    int lat;
    bit err;
    bit hold;
  } vec_t;
  typedef struct {
    logic [3:0] cpl;
    logic [511:0] rd;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  exp_t exp_q[$];
  logic [511:0] last_rd = '0;
  vec_t tbl[7];

  mem_arbiter_rr_if #(.N_PORTS(4), .ADDR_W(64), .LINE_W(512)) bus ();
  mem_arbiter_rr #(.N_PORTS(4), .ADDR_W(64), .LINE_W(512), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string n, input logic [511:0] a, input logic [511:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.port_complete !== 4'b0 || bus.port_err !== 1'b0)) begin
      if (exp_q.size() == 0) chk("unexpected_complete", {bus.port_err, bus.port_complete}, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("complete", bus.port_complete, e.cpl);
        chk("err", bus.port_err, e.err);
        chk("rdata", bus.port_rdata, e.rd);
      end
    end
  end

  task automatic check_zero(input string n);
    chk({n, "_mem_req"}, bus.mem_req, 0);
    chk({n, "_addr"}, bus.mem_address, 0);
    chk({n, "_wr"}, bus.mem_wr_en, 0);
    chk({n, "_wdata"}, bus.mem_data_out, 0);
    chk({n, "_rdata"}, bus.port_rdata, 0);
    chk({n, "_cpl"}, {bus.port_err, bus.port_complete}, 0);
  endtask

  task automatic txn(input vec_t v);
    logic [511:0] wd;
    wd = {64{v.wb}};
    bus.port_req[v.port] = 1'b1;
    bus.port_wr_en[v.port] = v.wr;
    bus.port_addr[v.port*64 +: 64] = v.addr;
    bus.port_wdata[v.port*512 +: 512] = wd;
    if (v.err) exp_q.push_back('{4'b1 << v.port, last_rd, 1'b1});
    tick;
    chk("req_hi", bus.mem_req, 1);
    chk("mem_addr", bus.mem_address, v.addr);
    chk("mem_wr", bus.mem_wr_en, v.wr);
    chk("mem_wdata", bus.mem_data_out, wd);
    if (v.err) begin
      int n;
      n = 1;
      for (int i = 0; i < 40 && bus.mem_req; i++) begin
        tick;
        if (bus.mem_req) n++;
      end
      chk("tmo_busy_cycles", n, 8);
    end else begin
      for (int i = 1; i < v.lat; i++) begin
        tick;
        chk("busy_stable", {bus.mem_req, bus.mem_wr_en, bus.mem_address, bus.mem_data_out[63:0]},
            {1'b1, v.wr, v.addr, wd[63:0]});
      end
      if (!v.wr) last_rd = {64{v.rb}};
      exp_q.push_back('{4'b1 << v.port, last_rd, 1'b0});
      bus.mem_data_valid = 1'b1;
      bus.data_from_mem = {64{v.rb}};
      tick;
      bus.mem_data_valid = v.hold;
      bus.data_from_mem = {64{~v.rb}};
      chk("resp_req_lo", bus.mem_req, 0);
    end
    tick;
    bus.mem_data_valid = 1'b0;
    bus.port_req[v.port] = 1'b0;
    chk("rdata_hold", bus.port_rdata, last_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1'b0, 64'h1000, 8'h00, 8'hA5, 6, 1'b0, 1'b0};
    tbl[1] = '{2, 1'b1, 64'h2040, 8'h5A, 8'h33, 3, 1'b0, 1'b0};
    tbl[2] = '{1, 1'b0, 64'h3080, 8'h00, 8'hC3, 1, 1'b0, 1'b1};
    tbl[3] = '{3, 1'b0, 64'h40C0, 8'h00, 8'h00, 0, 1'b1, 1'b0};
    tbl[4] = '{3, 1'b0, 64'h40C0, 8'h00, 8'h7E, 2, 1'b0, 1'b0};
    tbl[5] = '{1, 1'b0, 64'h6000, 8'h00, 8'h9C, 8, 1'b0, 1'b0};
    tbl[6] = '{0, 1'b1, 64'h5000, 8'h11, 8'h22, 1, 1'b0, 1'b0};
    bus.port_req = '0;
    bus.port_wr_en = '0;
    bus.port_addr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.port_wdata = '0;
    bus.data_from_mem = '0;
    bus.mem_data_valid = 1'b0;
    repeat (2) tick;
    check_zero("reset");
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) txn(tbl[i]);
    bus.port_req = 4'b0010;
    bus.port_addr[64 +: 64] = 64'h7000;
    tick;
    tick;
    chk("pre_rst_busy", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    last_rd = '0;
    bus.port_req = '0;
    repeat (2) tick;
    rst_n = 1'b1;
    bus.mem_data_valid = 1'b1;
    tick;
    bus.mem_data_valid = 1'b0;
    chk("spur_idle_req", bus.mem_req, 0);
    tick;
    chk("spur_idle_cpl", bus.port_complete, 0);
    for (int p = 0; p < 4; p++) bus.port_addr[p*64 +: 64] = 64'h10000 + 64'(p) * 64'h100;
    bus.port_wr_en = '0;
    bus.port_req = 4'hF;
    tick;
    for (int it = 0; it < 6; it++) begin
      chk("rot_addr", bus.mem_address, 64'h10000 + 64'(it % 4) * 64'h100);
      last_rd = {64{8'(8'h10 + it)}};
      exp_q.push_back('{4'b1 << (it % 4), last_rd, 1'b0});
      bus.mem_data_valid = 1'b1;
      bus.data_from_mem = last_rd;
      tick;
      bus.mem_data_valid = 1'b0;
      chk("rot_cpl", bus.port_complete, 4'b1 << (it % 4));
      tick;
      chk("rot_idle", bus.mem_req, 0);
      if (it == 5) bus.port_req = '0;
      tick;
    end
    chk("rot_end_idle", bus.mem_req, 0);
    repeat (2) tick;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
